// File: rtl/mem_bus_responder.sv
// 8085 multiplexed-bus slave: latches the address on ALE, decodes a RAM window and one
// I/O port, inserts READY wait states, drives read data and commits write data.
module mem_bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h2000,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [7:0]  IO_PORT     = 8'h20
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       ale,
    input  logic [7:0] ad_in,
    input  logic [7:0] a_hi,
    input  logic       io_m,
    input  logic       rd_n,
    input  logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ready,
    output logic [7:0] io_out,
    input  logic [7:0] io_in,
    output logic       bus_err
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACTIVE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              io_m_q;
    logic              is_wr_q;
    logic [3:0]        cnt_q;
    logic [7:0]        wdata_q;
    logic [7:0]        ad_out_q;
    logic [7:0]        io_out_q;
    logic              ready_q;
    logic              ad_oe_q;
    logic              bus_err_q;

    logic [7:0]        mem [2**ADDR_W];

    logic [15:0]       addr_in;
    logic              sel_in;
    logic              both_low;
    logic              one_low;
    logic              strb_rel;
    logic [7:0]        rd_data;
    logic              mem_we;

    assign addr_in  = {a_hi, ad_in};
    assign sel_in   = io_m ? (ad_in == IO_PORT)
                           : (addr_in[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
    assign both_low = ~rd_n & ~wr_n;
    assign one_low  = rd_n ^ wr_n;
    // Release is judged on the strobe that opened the access.
    assign strb_rel = is_wr_q ? wr_n : rd_n;
    assign rd_data  = io_m_q ? io_in : mem[addr_q];
    assign mem_we   = ~reset & ~ale & (state_q == ACTIVE) & is_wr_q & wr_n & ~io_m_q;

    // RAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_out) begin
        if (mem_we)
            mem[addr_q] <= wdata_q;
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            io_m_q    <= 1'b0;
            is_wr_q   <= 1'b0;
            cnt_q     <= 4'd0;
            wdata_q   <= 8'h00;
            ad_out_q  <= 8'h00;
            io_out_q  <= 8'h00;
            ready_q   <= 1'b1;
            ad_oe_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (ale) begin
                addr_q  <= addr_in[ADDR_W-1:0];
                io_m_q  <= io_m;
                ad_oe_q <= 1'b0;
                ready_q <= 1'b1;
                state_q <= sel_in ? ADDR : IDLE;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (both_low) begin
                            bus_err_q <= 1'b1;
                            ready_q   <= 1'b1;
                            ad_oe_q   <= 1'b0;
                            state_q   <= IDLE;
                        end else if (one_low) begin
                            is_wr_q <= ~wr_n;
                            if (WAIT_STATES == 0) begin
                                state_q <= ACTIVE;
                                if (!rd_n) begin
                                    ad_out_q <= rd_data;
                                    ad_oe_q  <= 1'b1;
                                end else begin
                                    wdata_q  <= ad_in;
                                end
                            end else begin
                                ready_q <= 1'b0;
                                cnt_q   <= CNT_INIT;
                                state_q <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (both_low) begin
                            bus_err_q <= 1'b1;
                            ready_q   <= 1'b1;
                            ad_oe_q   <= 1'b0;
                            state_q   <= IDLE;
                        end else if (strb_rel) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else if (cnt_q == 4'd0) begin
                            ready_q <= 1'b1;
                            state_q <= ACTIVE;
                            if (!is_wr_q) begin
                                ad_out_q <= rd_data;
                                ad_oe_q  <= 1'b1;
                            end else begin
                                wdata_q  <= ad_in;
                            end
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    ACTIVE: begin
                        if (both_low) begin
                            bus_err_q <= 1'b1;
                            ready_q   <= 1'b1;
                            ad_oe_q   <= 1'b0;
                            state_q   <= IDLE;
                        end else if (strb_rel) begin
                            ad_oe_q <= 1'b0;
                            if (is_wr_q && io_m_q)
                                io_out_q <= wdata_q;
                            state_q <= IDLE;
                        end else if (is_wr_q) begin
                            wdata_q <= ad_in;
                        end
                    end
                endcase
            end
        end
    end

    assign ad_out  = ad_out_q;
    assign ad_oe   = ad_oe_q;
    assign ready   = ready_q;
    assign io_out  = io_out_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one bus; a vector
// table drives the 1-wait instance, hand sequences cover wait-count corners.
module tb_mem_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ale, io_m, rd_n, wr_n;
    logic [7:0] ad_in, a_hi, io_in;
    logic [7:0] ad_out0, io_out0, ad_out1, io_out1, ad_out3, io_out3;
    logic       oe0, rdy0, err0, oe1, rdy1, err1, oe3, rdy3, err3;

    mem_bus_responder #(.WAIT_STATES(0)) u0 (
        .clk_out(clk), .reset(rst), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .io_m(io_m),
        .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out0), .ad_oe(oe0), .ready(rdy0),
        .io_out(io_out0), .io_in(io_in), .bus_err(err0));
    mem_bus_responder #(.WAIT_STATES(1)) u1 (
        .clk_out(clk), .reset(rst), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .io_m(io_m),
        .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out1), .ad_oe(oe1), .ready(rdy1),
        .io_out(io_out1), .io_in(io_in), .bus_err(err1));
    mem_bus_responder #(.WAIT_STATES(3)) u3 (
        .clk_out(clk), .reset(rst), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .io_m(io_m),
        .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out3), .ad_oe(oe3), .ready(rdy3),
        .io_out(io_out3), .io_in(io_in), .bus_err(err3));

    typedef struct {
        string       nm;
        logic        r, a, im, rn, wn;
        logic [15:0] adr;
        logic [7:0]  d, ii;
        logic [18:0] exp;   // {ready, ad_oe, ad_out, io_out, bus_err}
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [18:0] ex(input logic r, input logic oe, input logic [7:0] o,
                                       input logic [7:0] io, input logic e);
        return {r, oe, o, io, e};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic a, input logic im,
                                input logic rn, input logic wn, input logic [15:0] adr,
                                input logic [7:0] d, input logic [7:0] ii, input logic [18:0] e);
        vec_t v;
        v.nm = nm; v.r = r; v.a = a; v.im = im; v.rn = rn; v.wn = wn;
        v.adr = adr; v.d = d; v.ii = ii; v.exp = e;
        return v;
    endfunction

    task automatic drv(input logic r, input logic a, input logic im, input logic rn,
                       input logic wn, input logic [15:0] adr, input logic [7:0] d);
        rst   = r;
        ale   = a;
        io_m  = im;
        rd_n  = rn;
        wr_n  = wn;
        a_hi  = adr[15:8];
        ad_in = a ? adr[7:0] : d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr_long(input logic [15:0] adr, input logic [7:0] d);
        drv(0, 1, 0, 1, 1, adr, 8'h00); tick();
        repeat (5) begin drv(0, 0, 0, 1, 0, adr, d); tick(); end
        drv(0, 0, 0, 1, 1, adr, d); tick();
    endtask

    initial begin
        io_in = 8'h00;
        drv(1, 0, 0, 1, 1, 16'h0000, 8'h00);

        tv.push_back(mk("rst",     1,0,0,1,1,16'h0000,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        for (int i = 0; i < 10; i++)
            tv.push_back(mk("idle", 0,0,0,1,1,16'h0000,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("w_ale",   0,1,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("w_e1",    0,0,0,1,0,16'h2010,8'hA5,8'h00, ex(0,0,8'h00,8'h00,0)));
        tv.push_back(mk("w_act",   0,0,0,1,0,16'h2010,8'hA5,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("w_exit",  0,0,0,1,1,16'h2010,8'hA5,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("r_ale",   0,1,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("r_e1",    0,0,0,0,1,16'h2010,8'h00,8'h00, ex(0,0,8'h00,8'h00,0)));
        tv.push_back(mk("r_act",   0,0,0,0,1,16'h2010,8'h00,8'h00, ex(1,1,8'hA5,8'h00,0)));
        tv.push_back(mk("r_hold",  0,0,0,0,1,16'h2010,8'h00,8'h00, ex(1,1,8'hA5,8'h00,0)));
        tv.push_back(mk("r_exit",  0,0,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("o_ale",   0,1,1,1,1,16'h2020,8'h00,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("o_e1",    0,0,1,1,0,16'h2020,8'h3C,8'h00, ex(0,0,8'hA5,8'h00,0)));
        tv.push_back(mk("o_act",   0,0,1,1,0,16'h2020,8'h3C,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("o_exit",  0,0,1,1,1,16'h2020,8'h3C,8'h00, ex(1,0,8'hA5,8'h3C,0)));
        tv.push_back(mk("i_ale",   0,1,1,1,1,16'h2020,8'h00,8'h77, ex(1,0,8'hA5,8'h3C,0)));
        tv.push_back(mk("i_e1",    0,0,1,0,1,16'h2020,8'h00,8'h77, ex(0,0,8'hA5,8'h3C,0)));
        tv.push_back(mk("i_act",   0,0,1,0,1,16'h2020,8'h00,8'h77, ex(1,1,8'h77,8'h3C,0)));
        tv.push_back(mk("i_exit",  0,0,1,1,1,16'h2020,8'h00,8'h77, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("n_ale",   0,1,1,1,1,16'h2121,8'h00,8'h55, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("n_rd1",   0,0,1,0,1,16'h2121,8'h00,8'h55, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("n_rd2",   0,0,1,0,1,16'h2121,8'h00,8'h55, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("n_exit",  0,0,1,1,1,16'h2121,8'h00,8'h55, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("b_ale",   0,1,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("b_both",  0,0,0,0,0,16'h2010,8'hEE,8'h00, ex(1,0,8'h77,8'h3C,1)));
        tv.push_back(mk("b_both2", 0,0,0,0,0,16'h2010,8'hEE,8'h00, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("b_rel",   0,0,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("x_ale",   0,1,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h77,8'h3C,0)));
        tv.push_back(mk("x_e1",    0,0,0,0,1,16'h2010,8'h00,8'h00, ex(0,0,8'h77,8'h3C,0)));
        tv.push_back(mk("x_act",   0,0,0,0,1,16'h2010,8'h00,8'h00, ex(1,1,8'hA5,8'h3C,0)));
        tv.push_back(mk("x_rst",   1,0,0,0,1,16'h2010,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("x_idle",  0,0,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("y_ale",   0,1,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'h00,8'h00,0)));
        tv.push_back(mk("y_e1",    0,0,0,0,1,16'h2010,8'h00,8'h00, ex(0,0,8'h00,8'h00,0)));
        tv.push_back(mk("y_act",   0,0,0,0,1,16'h2010,8'h00,8'h00, ex(1,1,8'hA5,8'h00,0)));
        tv.push_back(mk("y_exit",  0,0,0,1,1,16'h2010,8'h00,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("z_ale",   0,1,0,1,1,16'h2011,8'h00,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("z_e1",    0,0,0,1,0,16'h2011,8'h5A,8'h00, ex(0,0,8'hA5,8'h00,0)));
        tv.push_back(mk("z_act",   0,0,0,1,0,16'h2011,8'h5A,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("z_exit",  0,0,0,1,1,16'h2011,8'h5A,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("q_ale",   0,1,0,1,1,16'h2011,8'h00,8'h00, ex(1,0,8'hA5,8'h00,0)));
        tv.push_back(mk("q_e1",    0,0,0,0,1,16'h2011,8'h00,8'h00, ex(0,0,8'hA5,8'h00,0)));
        tv.push_back(mk("q_act",   0,0,0,0,1,16'h2011,8'h00,8'h00, ex(1,1,8'h5A,8'h00,0)));
        tv.push_back(mk("q_exit",  0,0,0,1,1,16'h2011,8'h00,8'h00, ex(1,0,8'h5A,8'h00,0)));

        for (int i = 0; i < tv.size(); i++) begin
            drv(tv[i].r, tv[i].a, tv[i].im, tv[i].rn, tv[i].wn, tv[i].adr, tv[i].d);
            io_in = tv[i].ii;
            tick();
            chk(tv[i].nm, {13'b0, rdy1, oe1, ad_out1, io_out1, err1}, {13'b0, tv[i].exp});
        end

        // Top byte of the window with 0 vs 3 wait states
        wr_long(16'h20FF, 8'h5C);
        wr_long(16'h2030, 8'h11);
        drv(0, 1, 0, 1, 1, 16'h20FF, 8'h00); tick();
        chk("ws_addr", {30'b0, rdy0, rdy3}, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            drv(0, 0, 0, 0, 1, 16'h20FF, 8'h00); tick();
            chk($sformatf("ws_k%0d", k), {28'b0, rdy0, oe0, rdy3, oe3},
                {28'b0, 1'b1, 1'b1, (k >= 4), (k >= 4)});
        end
        chk("ws_data", {16'b0, ad_out0, ad_out3}, 32'h5C5C);
        drv(0, 0, 0, 1, 1, 16'h20FF, 8'h00); tick();
        chk("ws_rel", {30'b0, oe0, oe3}, 32'h0);

        // One past the window: no response at any wait setting
        drv(0, 1, 0, 1, 1, 16'h2100, 8'h00); tick();
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 0, 0, 1, 16'h2100, 8'h00); tick();
            chk($sformatf("oob_k%0d", k), {26'b0, rdy0, oe0, rdy1, oe1, rdy3, oe3}, 32'h2A);
        end
        drv(0, 0, 0, 1, 1, 16'h2100, 8'h00); tick();

        // Write strobe released mid-wait on the 3-wait instance
        drv(0, 1, 0, 1, 1, 16'h2030, 8'h00); tick();
        drv(0, 0, 0, 1, 0, 16'h2030, 8'h99); tick();
        chk("ab_wait", {31'b0, rdy3}, 32'h0);
        drv(0, 0, 0, 1, 1, 16'h2030, 8'h99); tick();
        chk("ab_rel", {30'b0, rdy3, oe3}, 32'h2);
        tick();
        chk("ab_idle", {31'b0, rdy3}, 32'h1);
        drv(0, 1, 0, 1, 1, 16'h2030, 8'h00); tick();
        repeat (5) begin drv(0, 0, 0, 0, 1, 16'h2030, 8'h00); tick(); end
        chk("ab_keep", {23'b0, oe3, ad_out3}, {23'b0, 1'b1, 8'h11});
        drv(0, 0, 0, 1, 1, 16'h2030, 8'h00); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
